// File: rtl/spi_accel_responder_pkg.sv
// Shared definitions for the accelerometer SPI responder: command codes,
// register-map sizing defaults, FSM state encoding and the pointer
// auto-increment helper used by burst reads and writes.
package spi_accel_responder_pkg;

  localparam int          REG_COUNT_DEF = 20;
  localparam int          RO_COUNT_DEF  = 4;
  localparam logic [7:0]  CMD_WRITE_DEF = 8'h0A;
  localparam logic [7:0]  CMD_READ_DEF  = 8'h0B;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_RD,
    ST_ADDR_WR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_IGNORE
  } state_t;

  // Burst pointer advance: wraps to 0 after the last implemented register.
  // Pointers that start above the map run on to 8'hFF and wrap naturally.
  function automatic logic [7:0] next_ptr(input logic [7:0] p, input int reg_count);
    return (p == 8'(reg_count - 1)) ? 8'd0 : p + 8'd1;
  endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pins plus the write-observation strobe bus of the accelerometer responder.
// Ports: CS/MOSI from the master, MISO back; wr_strobe/wr_addr/wr_data report
// each committed write. master modport = SPI master side, slave = responder.
interface spi_accel_responder_if;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output CS, MOSI, input MISO, wr_strobe, wr_addr, wr_data);
  modport slave  (input CS, MOSI, output MISO, wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/spi_accel_responder_shift_byte.sv
// MOSI deserializer (spi_shift_byte): shifts bits on SCLK rising, counts them
// in bit_cnt and flags byte_done on the 8th bit; byte_val is the full byte
// including the bit being sampled. CS high asynchronously clears bit_cnt.
// Ports: SCLK, resetn, cs, mosi in; bit_cnt, byte_done, byte_val out.
module spi_accel_responder_shift_byte (
  input  logic       SCLK,
  input  logic       resetn,
  input  logic       cs,
  input  logic       mosi,
  output logic [2:0] bit_cnt,
  output logic       byte_done,
  output logic [7:0] byte_val
);
  logic [6:0] sr;

  always_ff @(posedge SCLK or posedge cs) begin
    if (cs)
      bit_cnt <= 3'd0;
    else if (!resetn)
      bit_cnt <= 3'd0;
    else
      bit_cnt <= bit_cnt + 3'd1;
  end

  // Stale bits left by an aborted byte are harmless: bit_cnt restarts at 0,
  // so all seven history bits are overwritten before the next byte_done.
  always_ff @(posedge SCLK) begin
    sr <= {sr[5:0], mosi};
  end

  // bit_cnt is held at 0 while CS is high, so byte_done cannot fire then.
  assign byte_done = (bit_cnt == 3'd7);
  assign byte_val  = {sr, mosi};
endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave modelling the accelerometer register map (0x0B read,
// 0x0A write, address byte, auto-incrementing data burst).
// Ports: SCLK (block clock), resetn (sync, active-low), bus (slave modport).
module spi_accel_responder
  import spi_accel_responder_pkg::*;
#(
  parameter int         REG_COUNT = REG_COUNT_DEF,
  parameter int         RO_COUNT  = RO_COUNT_DEF,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF
) (
  input  logic                  SCLK,
  input  logic                  resetn,
  spi_accel_responder_if.slave  bus
);
  logic       cs;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] byte_val;

  state_t     state;
  logic [7:0] regs [REG_COUNT];
  logic [7:0] ptr;
  logic [7:0] tx_byte;
  logic       miso_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic [7:0] nxt;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_ok;

  assign cs = bus.CS;

  spi_accel_responder_shift_byte u_shift (
    .SCLK      (SCLK),
    .resetn    (resetn),
    .cs        (cs),
    .mosi      (bus.MOSI),
    .bit_cnt   (bit_cnt),
    .byte_done (byte_done),
    .byte_val  (byte_val)
  );

  assign nxt   = next_ptr(ptr, REG_COUNT);
  assign wr_ok = (ptr >= 8'(RO_COUNT)) && (ptr < 8'(REG_COUNT));

  // One read port serves both the address phase (first byte of a burst)
  // and the data phase (prefetch of the following byte).
  always_comb begin
    rd_addr = (state == ST_ADDR_RD) ? byte_val : nxt;
    rd_data = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rd_addr == 8'(i)) rd_data = regs[i];
    end
  end

  // Frame control; CS high aborts the frame asynchronously.
  always_ff @(posedge SCLK or posedge cs) begin
    if (cs) begin
      state <= ST_CMD;
    end else if (!resetn) begin
      state <= ST_CMD;
    end else if (byte_done) begin
      case (state)
        ST_CMD: begin
          if (byte_val == CMD_READ)       state <= ST_ADDR_RD;
          else if (byte_val == CMD_WRITE) state <= ST_ADDR_WR;
          else                            state <= ST_IGNORE;
        end
        ST_ADDR_RD: state <= ST_DATA_RD;
        ST_ADDR_WR: state <= ST_DATA_WR;
        default:    state <= state;
      endcase
    end
  end

  // Register file, burst pointer and write-observation outputs. These
  // survive a CS abort; only resetn reinitialises them.
  always_ff @(posedge SCLK) begin
    if (!resetn) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'(i);
      ptr         <= 8'd0;
      tx_byte     <= 8'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (byte_done) begin
        case (state)
          ST_ADDR_RD: begin
            ptr     <= byte_val;
            tx_byte <= rd_data;
          end
          ST_ADDR_WR: ptr <= byte_val;
          ST_DATA_RD: begin
            ptr     <= nxt;
            tx_byte <= rd_data;
          end
          ST_DATA_WR: begin
            if (wr_ok) begin
              for (int i = 0; i < REG_COUNT; i++) begin
                if (ptr == 8'(i)) regs[i] <= byte_val;
              end
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr;
              wr_data_q   <= byte_val;
            end
            ptr <= nxt;
          end
          default: ;
        endcase
      end
    end
  end

  // MISO launches on the falling edge so the master samples a settled bit.
  always_ff @(negedge SCLK or posedge cs) begin
    if (cs)
      miso_q <= 1'b0;
    else if (!resetn)
      miso_q <= 1'b0;
    else if (state == ST_DATA_RD)
      miso_q <= tx_byte[3'd7 - bit_cnt];
    else
      miso_q <= 1'b0;
  end

  assign bus.MISO      = cs ? 1'b0 : miso_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule
